// File: rtl/dma_crc_engine.sv
// dma_crc_engine: snapshots a word buffer and folds one word per clock into a
// parametrised CRC. The register can be seeded from the previous residue, so a
// single CRC can span several DMA bursts.
module dma_crc_engine #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WORDS = 8,
  parameter int unsigned CRC_W     = 32,
  parameter logic [63:0] POLY      = 64'h0000_0000_04C1_1DB7,
  parameter logic [63:0] INIT      = 64'h0000_0000_FFFF_FFFF,
  parameter bit          REFLECT   = 1'b1,
  parameter logic [63:0] XOR_OUT   = 64'h0000_0000_FFFF_FFFF
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                start_i,
  input  logic                                chain_i,
  input  logic [$clog2(NUM_WORDS+1)-1:0]      len_i,
  input  logic [NUM_WORDS-1:0][DATA_W-1:0]    data_reg_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic [CRC_W-1:0]                    crc_o,
  output logic                                crc_valid_o
);

  localparam int unsigned LEN_W = $clog2(NUM_WORDS + 1);

  // Reverse the bit order of a CRC-wide value.
  function automatic logic [CRC_W-1:0] bit_rev(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(CRC_W); i++) begin
      r[i] = v[int'(CRC_W) - 1 - i];
    end
    return r;
  endfunction

  localparam logic [CRC_W-1:0] POLY_C = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] POLY_R = bit_rev(POLY[CRC_W-1:0]);
  localparam logic [CRC_W-1:0] INIT_C = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_C  = XOR_OUT[CRC_W-1:0];

  // Fully unrolled bit-serial LFSR update over one data word.
  function automatic logic [CRC_W-1:0] fold_word(input logic [CRC_W-1:0] crc,
                                                 input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (REFLECT) begin
        fb = c[0] ^ data[i];
        c  = c >> 1;
        if (fb) c = c ^ POLY_R;
      end else begin
        fb = c[CRC_W-1] ^ data[int'(DATA_W) - 1 - i];
        c  = c << 1;
        if (fb) c = c ^ POLY_C;
      end
    end
    return c;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FINAL = 2'd2
  } state_e;

  state_e                           state_q, state_d;
  logic [NUM_WORDS-1:0][DATA_W-1:0] buf_q, buf_d;
  logic [LEN_W-1:0]                 len_q, len_d;
  logic [LEN_W-1:0]                 idx_q, idx_d;
  logic [CRC_W-1:0]                 work_q, work_d;
  logic [CRC_W-1:0]                 residue_q, residue_d;
  logic [CRC_W-1:0]                 crc_q, crc_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             valid_q, valid_d;

  logic [LEN_W-1:0]                 len_clamp_c;
  logic [DATA_W-1:0]                word_c;
  logic                             last_word_c;

  // Clamp the requested length to the buffer depth.
  always_comb begin
    len_clamp_c = len_i;
    if (len_i > LEN_W'(NUM_WORDS)) len_clamp_c = LEN_W'(NUM_WORDS);
  end

  // Select the word at the current index from the snapshot.
  always_comb begin
    word_c = '0;
    for (int k = 0; k < int'(NUM_WORDS); k++) begin
      if (idx_q == LEN_W'(k)) word_c = buf_q[k];
    end
    last_word_c = (idx_q == (len_q - LEN_W'(1)));
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      work_q    <= INIT_C;
      residue_q <= INIT_C;
      crc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      work_q    <= work_d;
      residue_q <= residue_d;
      crc_q     <= crc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = (len_clamp_c != '0) ? S_CALC : S_FINAL;
      end
      S_CALC: begin
        if (last_word_c) state_d = S_FINAL;
      end
      S_FINAL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output register next values.
  always_comb begin
    buf_d     = buf_q;
    len_d     = len_q;
    idx_d     = idx_q;
    work_d    = work_q;
    residue_d = residue_q;
    crc_d     = crc_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    busy_d    = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          buf_d  = data_reg_i;
          len_d  = len_clamp_c;
          idx_d  = '0;
          work_d = chain_i ? residue_q : INIT_C;
        end
      end
      S_CALC: begin
        work_d = fold_word(work_q, word_c);
        idx_d  = idx_q + LEN_W'(1);
      end
      S_FINAL: begin
        residue_d = work_q;
        crc_d     = work_q ^ XOR_C;
        done_d    = 1'b1;
        valid_d   = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign crc_o       = crc_q;
  assign crc_valid_o = valid_q;

endmodule

// File: tb/tb_dma_crc_engine.sv
// Directed bench for dma_crc_engine: byte-wide CRC-32 / MPEG-2 / CCITT-FALSE
// instances driven in lockstep, plus a 32-bit-word CRC-32 instance.
module tb_dma_crc_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_i;

  // Byte-wide group (three CRC flavours share the stimulus).
  logic                 start_a, chain_a;
  logic [3:0]           len_a;
  logic [8:0][7:0]      data_a;
  logic                 busy0, done0, valid0;
  logic [31:0]          crc0;
  logic                 busy1, done1, valid1;
  logic [31:0]          crc1;
  logic                 busy2, done2, valid2;
  logic [15:0]          crc2;

  // Word-wide group.
  logic                 start_b, chain_b;
  logic [3:0]           len_b;
  logic [7:0][31:0]     data_b;
  logic                 busy3, done3, valid3;
  logic [31:0]          crc3;

  int checks = 0;
  int errors = 0;

  dma_crc_engine #(.DATA_W(8), .NUM_WORDS(9)) u0 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_a), .chain_i(chain_a),
    .len_i(len_a), .data_reg_i(data_a), .busy_o(busy0), .done_o(done0),
    .crc_o(crc0), .crc_valid_o(valid0));

  dma_crc_engine #(.DATA_W(8), .NUM_WORDS(9), .REFLECT(1'b0),
                   .XOR_OUT(64'h0)) u1 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_a), .chain_i(chain_a),
    .len_i(len_a), .data_reg_i(data_a), .busy_o(busy1), .done_o(done1),
    .crc_o(crc1), .crc_valid_o(valid1));

  dma_crc_engine #(.DATA_W(8), .NUM_WORDS(9), .CRC_W(16), .POLY(64'h1021),
                   .INIT(64'hFFFF), .REFLECT(1'b0), .XOR_OUT(64'h0)) u2 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_a), .chain_i(chain_a),
    .len_i(len_a), .data_reg_i(data_a), .busy_o(busy2), .done_o(done2),
    .crc_o(crc2), .crc_valid_o(valid2));

  dma_crc_engine #(.DATA_W(32), .NUM_WORDS(8)) u3 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_b), .chain_i(chain_b),
    .len_i(len_b), .data_reg_i(data_b), .busy_o(busy3), .done_o(done3),
    .crc_o(crc3), .crc_valid_o(valid3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC-32 (reflected, byte-at-a-time formulation).
  function automatic logic [31:0] crc32_ref(input logic [7:0] b [0:31],
                                            input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // Wait (bounded) for done on group A, starting at observation index n0.
  task automatic wait_a(input int n0, output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int n = n0; n <= 40; n++) begin
      if (busy0) bc++;
      if (done0) begin
        lat = n;
        break;
      end
      tick();
    end
  endtask

  task automatic run_a(output int lat, output int bc);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_a(1, lat, bc);
  endtask

  task automatic run_b(output int lat);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (done3) begin
        lat = n;
        break;
      end
      tick();
    end
  endtask

  initial begin : stim
    int lat, bc, ndone;
    logic [7:0]  bytes [0:31];
    logic [31:0] exp_wide;

    reset_i = 1'b1;
    start_a = 1'b0; chain_a = 1'b0; len_a = '0; data_a = '0;
    start_b = 1'b0; chain_b = 1'b0; len_b = '0; data_b = '0;
    repeat (3) tick();

    check("rst_busy",  64'(busy0),  64'h0);
    check("rst_done",  64'(done0),  64'h0);
    check("rst_crc",   64'(crc0),   64'h0);
    check("rst_valid", 64'(valid0), 64'h0);
    check("rst_crc_w", 64'(crc3),   64'h0);
    reset_i = 1'b0;
    tick();
    check("idle_busy", 64'(busy0), 64'h0);

    // CRC-32 check value over "123456789".
    for (int k = 0; k < 9; k++) data_a[k] = 8'h31 + 8'(k);
    len_a = 4'd9;
    chain_a = 1'b0;
    run_a(lat, bc);
    check("crc32_latency", 64'(lat), 64'd11);
    check("crc32_busy_cycles", 64'(bc), 64'd10);
    check("crc32_value", 64'(crc0), 64'hCBF4_3926);
    check("crc32_valid", 64'(valid0), 64'h1);
    check("crc32_busy_at_done", 64'(busy0), 64'h0);
    check("mpeg2_value", 64'(crc1), 64'h0376_E6E7);
    check("mpeg2_done", 64'(done1), 64'h1);
    check("mpeg2_valid", 64'(valid1), 64'h1);
    check("mpeg2_busy", 64'(busy1), 64'h0);
    check("ccitt_value", 64'(crc2), 64'h29B1);
    check("ccitt_done", 64'(done2), 64'h1);
    check("ccitt_valid", 64'(valid2), 64'h1);
    check("ccitt_busy", 64'(busy2), 64'h0);
    tick();
    check("done_one_cycle", 64'(done0), 64'h0);
    check("crc_held", 64'(crc0), 64'hCBF4_3926);

    // Chained: "1234" then "56789" accepted on the done cycle.
    data_a = '0;
    for (int k = 0; k < 4; k++) data_a[k] = 8'h31 + 8'(k);
    len_a = 4'd4;
    chain_a = 1'b0;
    run_a(lat, bc);
    check("chain1_latency", 64'(lat), 64'd6);
    check("chain1_value", 64'(crc0), 64'h9BE3_E0A3);
    data_a = '0;
    for (int k = 0; k < 5; k++) data_a[k] = 8'h35 + 8'(k);
    len_a = 4'd5;
    chain_a = 1'b1;
    run_a(lat, bc);
    check("chain2_latency", 64'(lat), 64'd7);
    check("chain2_value", 64'(crc0), 64'hCBF4_3926);
    check("chain2_mpeg2", 64'(crc1), 64'h0376_E6E7);
    check("chain2_ccitt", 64'(crc2), 64'h29B1);

    // Start pulse and buffer/len/chain changes during CALC are ignored.
    for (int k = 0; k < 9; k++) data_a[k] = 8'h31 + 8'(k);
    len_a = 4'd9;
    chain_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    data_a = '0;
    len_a = 4'd2;
    chain_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_a(3, lat, bc);
    check("robust_latency", 64'(lat), 64'd11);
    check("robust_value", 64'(crc0), 64'hCBF4_3926);

    // Reset in the middle of a 9-word job.
    for (int k = 0; k < 9; k++) data_a[k] = 8'h31 + 8'(k);
    len_a = 4'd9;
    chain_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("midrst_busy",  64'(busy0),  64'h0);
    check("midrst_valid", 64'(valid0), 64'h0);
    check("midrst_crc",   64'(crc0),   64'h0);
    check("midrst_done",  64'(done0),  64'h0);
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      if (done0) ndone++;
      tick();
    end
    check("midrst_no_done", 64'(ndone), 64'h0);
    chain_a = 1'b1;
    run_a(lat, bc);
    check("postrst_chain_latency", 64'(lat), 64'd11);
    check("postrst_chain_value", 64'(crc0), 64'hCBF4_3926);

    // Word-wide instance.
    check("wide_valid_cleared", 64'(valid3), 64'h0);
    data_b = '0;
    data_b[0] = 32'h3433_3231;
    data_b[1] = 32'h3837_3635;
    len_b = 4'd2;
    chain_b = 1'b0;
    run_b(lat);
    check("wide2_latency", 64'(lat), 64'd4);
    check("wide2_value", 64'(crc3), 64'h9AE0_DAAF);
    check("wide2_valid", 64'(valid3), 64'h1);

    len_b = 4'd0;
    run_b(lat);
    check("len0_latency", 64'(lat), 64'd2);
    check("len0_value", 64'(crc3), 64'h0);

    for (int k = 0; k < 8; k++) begin
      data_b[k] = 32'hA5C3_0F11 ^ (32'h0102_0408 * 32'(k + 1));
      for (int j = 0; j < 4; j++) bytes[4*k + j] = data_b[k][8*j +: 8];
    end
    exp_wide = crc32_ref(bytes, 32);
    len_b = 4'd15;
    run_b(lat);
    check("clamp_latency", 64'(lat), 64'd10);
    check("clamp_value", 64'(crc3), 64'(exp_wide));

    len_b = 4'd0;
    chain_b = 1'b1;
    run_b(lat);
    check("len0_chain_latency", 64'(lat), 64'd2);
    check("len0_chain_value", 64'(crc3), 64'(exp_wide));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
